piso_shift_register: RTL and testbench

//   Parallel-in/serial-out shift register built from D flip-flop stages.

---
 rtl/piso_shift_register.sv | 151 +++++++++++++++
 tb/tb_piso_shift_register.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out shift register: accepts a WIDTH-bit word over a
// valid/ready load handshake and emits it one bit per clock on sout_o.
// Latency: first bit appears the cycle after the accepting edge.
// Backpressure: shift_en_i=0 freezes the frame; load_ready_o is low while busy.
// Optional feature macro: PARITY_EN (appends one even-parity bit per frame).
//
// Ports:
//   clk_i          clock, all state updates on rising edge
//   rst_i          synchronous reset, active-high, highest priority
//   load_valid_i   load_data_i is presented for capture
//   load_ready_o   block can accept a word (idle and not in reset)
//   load_data_i    parallel word to serialize
//   shift_en_i     1 = advance one bit this cycle, 0 = stall
//   sout_o         current serial bit (registered)
//   sout_valid_o   sout_o carries a frame bit this cycle
//   busy_o         frame in progress
//   done_o         one-cycle pulse after the final frame bit
module piso_shift_register #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_en_i,
    output logic             sout_o,
    output logic             sout_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             par_q, par_d;

    assign load_ready_o = (state_q == ST_IDLE) & ~rst_i;
    assign busy_o       = (state_q != ST_IDLE);
    assign sout_o       = sout_q;
    assign sout_valid_o = valid_q;
    assign done_o       = done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        par_d   = par_q;

        case (state_q)
            ST_IDLE: begin
                sout_d  = 1'b0;
                valid_d = 1'b0;
                if (load_valid_i && load_ready_o) begin
                    // The first bit goes straight to the output register; the
                    // shift register keeps the full word and is consumed from
                    // the transmit end on every advance.
                    sr_d    = load_data_i;
                    cnt_d   = '0;
                    sout_d  = MSB_FIRST ? load_data_i[WIDTH-1] : load_data_i[0];
                    valid_d = 1'b1;
                    par_d   = ^load_data_i;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (shift_en_i) begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PARITY_EN
                        sout_d  = par_q;
                        cnt_d   = CW'(WIDTH);
                        state_d = ST_PARITY;
`else
                        sout_d  = 1'b0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        // sr_q still holds the bit currently on sout at its
                        // transmit end, so the next bit is one position in.
                        if (MSB_FIRST) begin
                            sr_d   = sr_q << 1;
                            sout_d = sr_q[WIDTH-2];
                        end else begin
                            sr_d   = sr_q >> 1;
                            sout_d = sr_q[1];
                        end
                    end
                end
            end

`ifdef PARITY_EN
            ST_PARITY: begin
                if (shift_en_i) begin
                    sout_d  = 1'b0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
`endif

            default: begin
                sout_d  = 1'b0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_shift_register.sv
module tb_piso_shift_register;

    localparam int W = 8;
`ifdef PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         shift_en = 1'b0;

    // Index 0: MSB-first instance, index 1: LSB-first instance.
    logic load_ready [2];
    logic sout       [2];
    logic sout_valid [2];
    logic busy       [2];
    logic done       [2];

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is just "word + position within the frame".
    logic [W-1:0] m_word  [2];
    int           m_pos   [2];
    bit           m_busy  [2];
    bit           m_valid [2];
    bit           m_done  [2];

    always #5 clk = ~clk;

    piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk), .rst_i(rst), .load_valid_i(load_valid),
        .load_ready_o(load_ready[0]), .load_data_i(load_data),
        .shift_en_i(shift_en), .sout_o(sout[0]), .sout_valid_o(sout_valid[0]),
        .busy_o(busy[0]), .done_o(done[0])
    );

    piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .rst_i(rst), .load_valid_i(load_valid),
        .load_ready_o(load_ready[1]), .load_data_i(load_data),
        .shift_en_i(shift_en), .sout_o(sout[1]), .sout_valid_o(sout_valid[1]),
        .busy_o(busy[1]), .done_o(done[1])
    );

    // Bit p of a frame: data bits in transmit order, then even parity.
    function automatic logic frame_bit(input bit msb, input logic [W-1:0] w, input int p);
        if (p >= W) return ^w;
        return msb ? w[W-1-p] : w[p];
    endfunction

    task automatic chk(input string tag, input int i, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%s] t=%0t observed=%b expected=%b", tag,
                   (i == 0) ? "msb" : "lsb", $time, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] = 0; m_valid[i] = 0; m_done[i] = 0; m_pos[i] = 0;
            end else if (!m_busy[i]) begin
                m_done[i] = 0;
                if (load_valid) begin
                    m_word[i] = load_data; m_pos[i] = 0;
                    m_busy[i] = 1; m_valid[i] = 1;
                end else begin
                    m_valid[i] = 0;
                end
            end else if (shift_en) begin
                if (m_pos[i] == FL - 1) begin
                    m_busy[i] = 0; m_valid[i] = 0; m_done[i] = 1;
                end else begin
                    m_pos[i]++;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            logic exp_sout;
            exp_sout = m_valid[i] ? frame_bit(i == 0, m_word[i], m_pos[i]) : 1'b0;
            chk({tag, ".sout"},       i, sout[i],       exp_sout);
            chk({tag, ".sout_valid"}, i, sout_valid[i], m_valid[i]);
            chk({tag, ".busy"},       i, busy[i],       m_busy[i]);
            chk({tag, ".done"},       i, done[i],       m_done[i]);
            chk({tag, ".load_ready"}, i, load_ready[i], !m_busy[i] && !rst);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #2;
        compare_all(tag);
    endtask

    task automatic load_word(input string tag, input logic [W-1:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick(tag);
        load_valid = 1'b0;
        load_data  = $urandom;   // data only needs to be stable at accept
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_word[i] = '0; m_pos[i] = 0; m_busy[i] = 0; m_valid[i] = 0; m_done[i] = 0;
        end

        // Reset: ready must stay low while rst is high.
        tick("reset");
        tick("reset");
        rst = 1'b0;
        #1;
        compare_all("post_reset");
        tick("idle");

        // MSB/LSB serialization with continuous shift_en, then done pulse.
        shift_en = 1'b1;
        load_word("a5", 8'hA5);
        for (int c = 0; c < FL + 2; c++) tick("a5");

        load_word("01", 8'h01);
        for (int c = 0; c < FL + 2; c++) tick("01");

        // Parity cases: 07 has odd popcount.
        load_word("07", 8'h07);
        for (int c = 0; c < FL + 2; c++) tick("07");

        // Stall after bit 2 for three cycles.
        load_word("f0", 8'hF0);
        tick("f0"); tick("f0");
        shift_en = 1'b0;
        for (int c = 0; c < 3; c++) tick("f0_stall");
        shift_en = 1'b1;
        for (int c = 0; c < FL + 2; c++) tick("f0");

        // Reset mid-frame: abort with no done pulse.
        load_word("ff", 8'hFF);
        tick("ff"); tick("ff"); tick("ff");
        rst = 1'b1;
        tick("ff_rst");
        rst = 1'b0;
        #1;
        compare_all("ff_rst_drop");
        tick("ff_after");
        tick("ff_after");

        // Continuous load_valid: second word only in the done cycle.
        load_valid = 1'b1;
        load_data  = 8'h3C;
        tick("3c");
        for (int c = 0; c < FL - 1; c++) tick("3c");
        load_data = 8'hC3;
        for (int c = 0; c < FL + 3; c++) tick("c3");
        load_valid = 1'b0;
        for (int c = 0; c < FL + 2; c++) tick("drain");

        // Randomized traffic including stalls and occasional resets.
        for (int c = 0; c < 600; c++) begin
            load_valid = ($urandom_range(0, 1) == 1);
            load_data  = $urandom;
            shift_en   = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 49) == 0);
            tick("rand");
        end
        rst = 1'b0;
        load_valid = 1'b0;
        shift_en = 1'b1;
        for (int c = 0; c < FL + 2; c++) tick("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
